vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_axis_counter.sv | 61 ++++++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: FSM state encoding and
// the default 800x600 @ 56 Hz (36 MHz pixel clock) timing constants.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } vga_state_e;

    localparam int unsigned VGA_H_ACTIVE = 800;
    localparam int unsigned VGA_H_FP     = 24;
    localparam int unsigned VGA_H_SYNC   = 72;
    localparam int unsigned VGA_H_BP     = 128;

    localparam int unsigned VGA_V_ACTIVE = 600;
    localparam int unsigned VGA_V_FP     = 1;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 22;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): position counter plus registered
// blank/sync flags that always describe the count presented in the same cycle.
module vga_axis_counter #(
    parameter int unsigned ACTIVE = 800,
    parameter int unsigned FP     = 24,
    parameter int unsigned SYNC   = 72,
    parameter int unsigned BP     = 128,
    parameter logic        POL    = 1'b1,
    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int unsigned W     = $clog2(TOTAL)
) (
    input  logic         clk36m,
    input  logic         reset,
    input  logic         ce,
    input  logic         step,
    input  logic         park,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         blank,
    output logic         blank_next,
    output logic         sync,
    output logic         wrap
);

    localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END   = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG  = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END  = W'(ACTIVE + FP + SYNC);
    // With no back porch the sync window runs to the last count, and its end
    // bound would not fit in W bits.
    localparam logic         SYNC_TAIL = (ACTIVE + FP + SYNC >= TOTAL);

    logic sync_on_next;

    assign wrap = (count == LAST);

    always_comb begin
        count_next = count;
        if (park)
            count_next = '0;
        else if (step)
            count_next = wrap ? '0 : count + 1'b1;
    end

    assign blank_next   = park || (count_next >= ACT_END);
    assign sync_on_next = !park && (count_next >= SYNC_BEG) &&
                          (SYNC_TAIL || (count_next < SYNC_END));

    always_ff @(posedge clk36m) begin
        if (reset) begin
            count <= '0;
            blank <= 1'b1;
            sync  <= ~POL;
        end else if (ce) begin
            count <= count_next;
            blank <= blank_next;
            sync  <= sync_on_next ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with IDLE/RUN/STOPPING run control; a stop
// request lets the current frame finish before the raster parks at (0,0).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk36m,
    input  logic          reset,
    input  logic          ce,
    input  logic          enable,
    output logic [HW-1:0] col,
    output logic [VW-1:0] row,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic          sol,
    output logic          sof,
    output logic          running
);

    vga_state_e    state, state_next;
    logic          advance, park, eof;
    logic          h_wrap, v_wrap, h_blank_next, v_blank_next;
    logic [HW-1:0] col_next;
    logic [VW-1:0] row_next;

    always_ff @(posedge clk36m) begin
        if (reset)
            state <= ST_IDLE;
        else if (ce)
            state <= state_next;
    end

    assign eof = h_wrap && v_wrap;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (enable) state_next = ST_RUN;
            ST_RUN:      if (!enable) state_next = ST_STOPPING;
            ST_STOPPING: begin
                if (enable)
                    state_next = ST_RUN;
                else if (eof)
                    state_next = ST_IDLE;
            end
            default:     state_next = ST_IDLE;
        endcase
    end

    // Leaving IDLE does not step: the counters already sit at (0,0), so the
    // first running cycle presents the origin.
    assign advance = (state != ST_IDLE);
    assign park    = (state_next == ST_IDLE);

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL)
    ) u_hcount (
        .clk36m     (clk36m),
        .reset      (reset),
        .ce         (ce),
        .step       (advance),
        .park       (park),
        .count      (col),
        .count_next (col_next),
        .blank      (hblank),
        .blank_next (h_blank_next),
        .sync       (hsync),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL)
    ) u_vcount (
        .clk36m     (clk36m),
        .reset      (reset),
        .ce         (ce),
        .step       (advance && h_wrap),
        .park       (park),
        .count      (row),
        .count_next (row_next),
        .blank      (vblank),
        .blank_next (v_blank_next),
        .sync       (vsync),
        .wrap       (v_wrap)
    );

    always_ff @(posedge clk36m) begin
        if (reset) begin
            running <= 1'b0;
            de      <= 1'b0;
            sol     <= 1'b0;
            sof     <= 1'b0;
        end else if (ce) begin
            running <= !park;
            de      <= !h_blank_next && !v_blank_next;
            sol     <= !park && (col_next == '0);
            sof     <= !park && (col_next == '0) && (row_next == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Drives four differently-parameterised generators in lockstep and compares
// every output, every cycle, against a frame-position reference model.
module tb_vga_timing_gen;

    logic clk36m = 1'b0;
    always #5 clk36m = ~clk36m;

    logic reset, ce, enable;

    typedef struct {
        int unsigned ha, hf, hs, hb, va, vf, vs, vb;
        logic        hp, vp;
    } tim_t;

    tim_t        T [4];
    int          m_st [4];   // 0 idle, 1 run, 2 stopping
    int unsigned m_p [4];    // linear pixel index within the frame

    int   n_cmp = 0, n_fail = 0, cyc = 0, ce_div = 1, ce_mode = 0, de_cnt = 0;

    // Observed word: col[31:20] row[19:8] hs vs hb vb de sol sof running
    logic [31:0] obs [4];

    logic [9:0] a_col, a_row, b_col, b_row;
    logic [4:0] c_col;
    logic [3:0] c_row, d_col;
    logic [2:0] d_row;
    logic [7:0] a_f, b_f, c_f, d_f;

    assign obs[0] = {12'(a_col), 12'(a_row), a_f};
    assign obs[1] = {12'(b_col), 12'(b_row), b_f};
    assign obs[2] = {12'(c_col), 12'(c_row), c_f};
    assign obs[3] = {12'(d_col), 12'(d_row), d_f};

    vga_timing_gen u_a (
        .clk36m(clk36m), .reset(reset), .ce(ce), .enable(enable),
        .col(a_col), .row(a_row), .hsync(a_f[7]), .vsync(a_f[6]),
        .hblank(a_f[5]), .vblank(a_f[4]), .de(a_f[3]), .sol(a_f[2]),
        .sof(a_f[1]), .running(a_f[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_b (
        .clk36m(clk36m), .reset(reset), .ce(ce), .enable(enable),
        .col(b_col), .row(b_row), .hsync(b_f[7]), .vsync(b_f[6]),
        .hblank(b_f[5]), .vblank(b_f[4]), .de(b_f[3]), .sol(b_f[2]),
        .sof(b_f[1]), .running(b_f[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_c (
        .clk36m(clk36m), .reset(reset), .ce(ce), .enable(enable),
        .col(c_col), .row(c_row), .hsync(c_f[7]), .vsync(c_f[6]),
        .hblank(c_f[5]), .vblank(c_f[4]), .de(c_f[3]), .sol(c_f[2]),
        .sof(c_f[1]), .running(c_f[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_d (
        .clk36m(clk36m), .reset(reset), .ce(ce), .enable(enable),
        .col(d_col), .row(d_row), .hsync(d_f[7]), .vsync(d_f[6]),
        .hblank(d_f[5]), .vblank(d_f[4]), .de(d_f[3]), .sol(d_f[2]),
        .sof(d_f[1]), .running(d_f[0])
    );

    function automatic int unsigned htot(int i);
        return T[i].ha + T[i].hf + T[i].hs + T[i].hb;
    endfunction

    function automatic int unsigned vtot(int i);
        return T[i].va + T[i].vf + T[i].vs + T[i].vb;
    endfunction

    function automatic logic [31:0] model_word(int i);
        int unsigned c, r;
        logic hb, vb, hsa, vsa;
        if (m_st[i] == 0)
            return {24'd0, ~T[i].hp, ~T[i].vp, 6'b110000};
        c   = m_p[i] % htot(i);
        r   = m_p[i] / htot(i);
        hb  = (c >= T[i].ha);
        vb  = (r >= T[i].va);
        hsa = (c >= T[i].ha + T[i].hf) && (c < T[i].ha + T[i].hf + T[i].hs);
        vsa = (r >= T[i].va + T[i].vf) && (r < T[i].va + T[i].vf + T[i].vs);
        return {12'(c), 12'(r), hsa ? T[i].hp : ~T[i].hp, vsa ? T[i].vp : ~T[i].vp,
                hb, vb, !hb && !vb, c == 0, m_p[i] == 0, 1'b1};
    endfunction

    task automatic model_step(int i);
        int unsigned total;
        total = htot(i) * vtot(i);
        if (reset) begin
            m_st[i] = 0;
            m_p[i]  = 0;
        end else if (ce) begin
            case (m_st[i])
                0: if (enable) begin m_st[i] = 1; m_p[i] = 0; end
                1: begin
                    m_p[i] = (m_p[i] + 1) % total;
                    if (!enable) m_st[i] = 2;
                end
                default: begin
                    if (enable) begin
                        m_st[i] = 1;
                        m_p[i]  = (m_p[i] + 1) % total;
                    end else if (m_p[i] == total - 1) begin
                        m_st[i] = 0;
                        m_p[i]  = 0;
                    end else begin
                        m_p[i] = m_p[i] + 1;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = model_word(i);
            n_cmp++;
            assert (obs[i] === exp) else begin
                n_fail++;
                $error("FAIL raster inst%0d cyc%0d: observed %h expected %h", i, cyc, obs[i], exp);
            end
        end
    endtask

    // Inputs change 1 time unit after an edge and are sampled at the next one.
    task automatic tick();
        if (ce_mode == 1)
            ce = ($urandom_range(3) != 0);
        else
            ce = ((cyc % ce_div) == 0);
        @(posedge clk36m);
        cyc++;
        for (int i = 0; i < 4; i++) model_step(i);
        #1;
        check_all();
        if (obs[2][3]) de_cnt++;
    endtask

    task automatic wait_sof_rise(input int budget, output int t, output logic ok);
        int   n;
        logic saw_low;
        n = 0;
        saw_low = !obs[2][1];
        while (!saw_low && n < budget) begin tick(); n++; saw_low = !obs[2][1]; end
        while (!obs[2][1] && n < budget) begin tick(); n++; end
        ok = saw_low && obs[2][1];
        t  = cyc;
    endtask

    initial begin
        int          t0, t1;
        logic        ok0, ok1, found;
        logic [31:0] prev, idle_c, idle_d;

        T[0] = '{800, 24, 72, 128, 600, 1, 2, 22, 1'b1, 1'b1};
        T[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        T[2] = '{10, 2, 3, 4, 5, 1, 2, 3, 1'b1, 1'b1};
        T[3] = '{6, 1, 2, 1, 3, 1, 1, 2, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin m_st[i] = 0; m_p[i] = 0; end
        idle_c = 32'h0000_0030;
        idle_d = 32'h0000_00F0;

        reset = 1'b1; enable = 1'b0; ce = 1'b1;
        #1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();

        // Continuous pixel clock: frame period and active-pixel count.
        enable = 1'b1;
        wait_sof_rise(400, t0, ok0);
        de_cnt = 0;
        wait_sof_rise(400, t1, ok1);
        n_cmp++;
        assert (ok0 && ok1 && (t1 - t0) == 209) else begin
            n_fail++;
            $error("FAIL sof_period_ce1: observed %0d expected 209", t1 - t0);
        end
        n_cmp++;
        assert (de_cnt == 50) else begin
            n_fail++;
            $error("FAIL de_count: observed %0d expected 50", de_cnt);
        end
        repeat (2100) tick();

        // Pixel enable one cycle in three.
        ce_div = 3;
        wait_sof_rise(1500, t0, ok0);
        wait_sof_rise(1500, t1, ok1);
        n_cmp++;
        assert (ok0 && ok1 && (t1 - t0) == 627) else begin
            n_fail++;
            $error("FAIL sof_period_ce3: observed %0d expected 627", t1 - t0);
        end
        ce_div = 1;

        // Stop request mid-frame: the frame must finish at its last pixel.
        repeat (50) tick();
        enable = 1'b0;
        found = 1'b0;
        prev  = obs[2];
        for (int n = 0; n < 500 && !found; n++) begin
            prev = obs[2];
            tick();
            found = !obs[2][0];
        end
        n_cmp++;
        assert (found && prev[31:20] == 12'd18 && prev[19:8] == 12'd10) else begin
            n_fail++;
            $error("FAIL stop_at_eof: observed found=%0d last=%h expected last col 18 row 10", found, prev);
        end

        // Reset asserted in the middle of a frame.
        enable = 1'b1;
        repeat (100) tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        assert (obs[2] === idle_c && obs[3] === idle_d) else begin
            n_fail++;
            $error("FAIL midframe_reset: observed %h/%h expected %h/%h", obs[2], obs[3], idle_c, idle_d);
        end
        reset = 1'b0;

        // Randomised pixel enable, run requests and occasional resets.
        ce_mode = 1;
        for (int n = 0; n < 20000; n++) begin
            if ($urandom_range(39) == 0) enable = ~enable;
            reset = ($urandom_range(399) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
